timer_time_counter: RTL

// - Consumer of timer_clk from timer_clk_gen: counts its rising edges into an MM:SS BCD time for the display driver.
// - Same sys_clk domain as the generator; adds start/halt control, a seconds prescaler and a lap-capture handshake.
// - Sits between timer_clk_gen and the 7-segment/display block; lap port is read by the display mux.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_bcd_digit.sv | 44 ++++
 rtl/timer_time_counter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS stopwatch time counter.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HALT  = 2'd3
   } timer_state_t;

   localparam logic [3:0] BCD_MAX_9 = 4'd9;
   localparam logic [3:0] BCD_MAX_5 = 4'd5;

   // Next value of a BCD digit that counts 0..max and wraps to 0.
   function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
      logic [3:0] r;
      if (d == max) begin
         r = 4'd0;
      end else begin
         r = d + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/timer_bcd_digit.sv
// One BCD digit of the time display; counts 0..MAX and emits a carry on wrap.
module timer_bcd_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX_9
)
(
   input  logic       sys_clk,
   input  logic       int_reset,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;

   // Clear dominates increment; otherwise the digit holds.
   always_comb begin
      digit_d = digit_q;
      if (clr) begin
         digit_d = 4'd0;
      end else if (inc) begin
         digit_d = bcd_next(digit_q, MAX);
      end else begin
         digit_d = digit_q;
      end
   end

   // Digit storage.
   always_ff @(posedge sys_clk or posedge int_reset) begin
      if (int_reset) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit = digit_q;
   // Carry ripples combinationally so the whole chain updates on one edge.
   assign carry = inc & ~clr & (digit_q == MAX);

endmodule

// File: rtl/timer_time_counter.sv
// Counts timer_clk rising edges into an MM:SS BCD time with run/pause/halt
// control, a seconds prescaler and a lap-capture handshake.
module timer_time_counter
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 10,
   parameter bit WRAP_EN       = 1'b0
)
(
   input  logic       sys_clk,
   input  logic       int_reset,
   input  logic       timer_clk,
   input  logic       timer_start,
   input  logic       timer_clear,
   input  logic       timer_pause,
   input  logic       lap_req,
   input  logic       lap_ack,
   output logic [3:0] sec_lo,
   output logic [3:0] sec_hi,
   output logic [3:0] min_lo,
   output logic [3:0] min_hi,
   output logic [3:0] lap_sec_lo,
   output logic [3:0] lap_sec_hi,
   output logic [3:0] lap_min_lo,
   output logic [3:0] lap_min_hi,
   output logic       lap_valid,
   output logic       lap_overrun,
   output logic       sec_tick,
   output logic       rollover,
   output logic       running
);

   localparam int            PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   timer_state_t  state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          timer_clk_q;
   logic          sec_tick_q, rollover_q;
   logic          lap_valid_q, lap_valid_d;
   logic          lap_overrun_q, lap_overrun_d;
   logic [15:0]   lap_time_q;

   logic tick, count_en, sec_step, at_max, digit_inc, lap_take;
   logic c_sl, c_sh, c_ml, c_mh;

   assign tick      = timer_clk & ~timer_clk_q;
   // Pause and clear both block counting; only RUN counts.
   assign count_en  = (state_q == RUN) & ~timer_clear & ~timer_pause & tick;
   assign sec_step  = count_en & (presc_q == PRESC_LAST);
   assign at_max    = (min_hi == BCD_MAX_9) & (min_lo == BCD_MAX_9) &
                      (sec_hi == BCD_MAX_5) & (sec_lo == BCD_MAX_9);
   // Without wrap, the increment out of 99:59 is swallowed and the FSM halts.
   assign digit_inc = sec_step & ~(at_max & ~WRAP_EN);
   // A lap is taken when the registers are free or being acknowledged now.
   assign lap_take  = lap_req & ~timer_clear & (~lap_valid_q | lap_ack);

   timer_bcd_digit #(.MAX(BCD_MAX_9)) u_sec_lo (
      .sys_clk(sys_clk), .int_reset(int_reset), .clr(timer_clear),
      .inc(digit_inc), .digit(sec_lo), .carry(c_sl));
   timer_bcd_digit #(.MAX(BCD_MAX_5)) u_sec_hi (
      .sys_clk(sys_clk), .int_reset(int_reset), .clr(timer_clear),
      .inc(c_sl), .digit(sec_hi), .carry(c_sh));
   timer_bcd_digit #(.MAX(BCD_MAX_9)) u_min_lo (
      .sys_clk(sys_clk), .int_reset(int_reset), .clr(timer_clear),
      .inc(c_sh), .digit(min_lo), .carry(c_ml));
   timer_bcd_digit #(.MAX(BCD_MAX_9)) u_min_hi (
      .sys_clk(sys_clk), .int_reset(int_reset), .clr(timer_clear),
      .inc(c_ml), .digit(min_hi), .carry(c_mh));

   // Prescaler: counts ticks in RUN, wraps at the terminal count.
   always_comb begin
      presc_d = presc_q;
      if (timer_clear) begin
         presc_d = {PW{1'b0}};
      end else if (count_en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = {PW{1'b0}};
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = presc_q;
      end
   end

   // FSM next state; clear overrides every transition including start.
   always_comb begin
      state_d = state_q;
      if (timer_clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (timer_start) begin
                  state_d = timer_pause ? PAUSE : RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (timer_pause) begin
                  state_d = PAUSE;
               end else if (sec_step && at_max && !WRAP_EN) begin
                  state_d = HALT;
               end else begin
                  state_d = RUN;
               end
            end
            PAUSE: begin
               if (!timer_pause) begin
                  state_d = RUN;
               end else begin
                  state_d = PAUSE;
               end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the state register.
   always_comb begin
      running = (state_q == RUN);
   end

   // Lap handshake flags: capture sets valid, ack alone clears it,
   // a request that finds unread data marks a sticky overrun.
   always_comb begin
      lap_valid_d   = lap_valid_q;
      lap_overrun_d = lap_overrun_q;
      if (timer_clear) begin
         lap_valid_d   = 1'b0;
         lap_overrun_d = 1'b0;
      end else if (lap_take) begin
         lap_valid_d   = 1'b1;
      end else if (lap_req) begin
         lap_overrun_d = 1'b1;
      end else if (lap_ack) begin
         lap_valid_d   = 1'b0;
      end else begin
         lap_valid_d   = lap_valid_q;
      end
   end

   // State, prescaler, edge detector and output pulse registers.
   always_ff @(posedge sys_clk or posedge int_reset) begin
      if (int_reset) begin
         state_q       <= IDLE;
         presc_q       <= {PW{1'b0}};
         timer_clk_q   <= 1'b0;
         sec_tick_q    <= 1'b0;
         rollover_q    <= 1'b0;
         lap_valid_q   <= 1'b0;
         lap_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         timer_clk_q   <= timer_clk;
         sec_tick_q    <= sec_step;
         rollover_q    <= c_mh & WRAP_EN;
         lap_valid_q   <= lap_valid_d;
         lap_overrun_q <= lap_overrun_d;
      end
   end

   // Lap time registers hold the pre-increment live time.
   always_ff @(posedge sys_clk or posedge int_reset) begin
      if (int_reset) begin
         lap_time_q <= 16'd0;
      end else if (timer_clear) begin
         lap_time_q <= 16'd0;
      end else if (lap_take) begin
         lap_time_q <= {min_hi, min_lo, sec_hi, sec_lo};
      end else begin
         lap_time_q <= lap_time_q;
      end
   end

   assign {lap_min_hi, lap_min_lo, lap_sec_hi, lap_sec_lo} = lap_time_q;
   assign lap_valid   = lap_valid_q;
   assign lap_overrun = lap_overrun_q;
   assign sec_tick    = sec_tick_q;
   assign rollover    = rollover_q;

endmodule
